xdevice_gen: RTL and testbench
==============================

# xdevice_gen

Parametrised traffic generator for the switch test environment. On each start pulse it emits a burst of NPKT packets, each an address/data pair, on a valid/ack source port feeding a switch ingress. Data follows either an incrementing pattern or an LFSR pattern. Pacing is programmable through an inter-packet gap, and the block reports busy, done and a transfer count for the bench and scoreboard.

## Interface
- DW, 4: data width; 2..16.
- AW, 2: address width; selects one of 2**AW switch ports.
- NPKT, 4: packets per burst; 1..255.
- INIT, 0: base value for the data and address patterns.
- GAP, 1: idle cycles between an accepted packet and the next valid; 0..15.
- TAPS, 4'b1100: LFSR feedback mask, DW bits wide. The default gives a maximal-length 4-bit sequence.

Ports:
- clk_i2  in  1  clock; all logic on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  begins a burst; honoured only in IDLE.
- mode_i  in  1  pattern select, 0 = incrementing, 1 = LFSR; sampled only when start_i is accepted.
- acktx  in  1  sink accepts the current packet; ignored while validtx = 0.
- adr_i  out  AW  destination port of the current packet.
- dat_i  out  DW  payload of the current packet.
- validtx  out  1  packet present on adr_i/dat_i.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle pulse when a burst completes.
- sent_o  out  8  count of packets accepted in the current or last burst.

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - validtx = 0.
  - On start_i: idx <= 0, sent_o <= 0, mode latched, packet 0 loaded into adr_i/dat_i, go to SEND.
- SEND:
  - validtx = 1; adr_i and dat_i are held stable until a transfer occurs.
  - A transfer is validtx & acktx at a clock edge; each transfer increments sent_o.
  - On a transfer with idx == NPKT-1: go to DONE.
  - On a transfer with GAP == 0: idx++, load the next packet, stay in SEND.
  - On a transfer otherwise: gap counter <= GAP, go to WAIT.
- WAIT:
  - validtx = 0; the gap counter decrements each cycle.
  - When the counter reaches 1: idx++, load the next packet, go to SEND.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- Pattern rules:
  - Incrementing data: dat = (INIT + 1 + 4*idx) mod 2**DW.
  - LFSR data: seed = (INIT + 1) mod 2**DW, with a seed of 0 replaced by 1. Each next packet: d <= {d[DW-2:0], ^(d & TAPS)}.
  - Address, both modes: adr = (INIT + idx) mod 2**AW.
- Boundary conditions:
  - start_i outside IDLE, including the DONE cycle, is ignored.
  - acktx in IDLE, WAIT or DONE is ignored.
  - acktx held permanently high gives one transfer per SEND cycle.
  - All pattern arithmetic wraps modulo the field width.
  - sent_o holds its value after DONE until the next accepted start.
- Reset, at any time including mid-burst:
  - state IDLE; validtx, busy_o, done_o, adr_i, dat_i, sent_o, idx and the gap counter all 0.
  - No pending ack is honoured. The next start restarts the burst at packet 0.

## Timing
- start_i sampled at edge t: validtx, adr_i and dat_i valid from t; busy_o high from t.
- Transfer at edge k with GAP > 0: validtx low after k for GAP cycles, next packet valid from edge k+GAP.
- Transfer at edge k with GAP == 0: the next packet replaces the current one at edge k and validtx stays high.
- Last transfer at edge k: validtx 0 and done_o 1 after k; done_o 0 and busy_o 0 after k+1.
- Minimum burst length, GAP = 0 with ack always high: NPKT + 2 cycles from start to IDLE.
- Reset assertion clears the outputs without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Reset mid-burst, asserted between clock edges: validtx, adr_i, dat_i and sent_o read 0 before the next edge. A subsequent start_i reproduces packet 0 exactly (dat 1, adr 0).
- Defaults, mode 0, acktx held 1: dat sequence 1, 5, 9, D; adr sequence 0, 1, 2, 3; one idle cycle between packets; single done_o pulse; sent_o = 4.
- Backpressure, acktx asserted 3 cycles after each validtx: adr_i, dat_i and validtx stable throughout each wait; sent_o steps 1..4; no packet is lost or duplicated.
- GAP = 0, acktx held 1: four transfers on four consecutive edges; validtx never drops mid-burst; done_o follows on the next cycle.
- LFSR, mode 1, DW = 4, TAPS = 4'b1100, INIT = 0, NPKT = 15: dat sequence 1, 2, 4, 9, 3, 6, D, A, 5, B, 7, F, E, C, 8; adr = idx mod 4.
- Protocol abuse:
  - start_i pulsed during SEND and during DONE: ignored.
  - acktx pulsed while in IDLE or WAIT: no change to sent_o.
  - INIT = 4'hF with mode 1: seed replaced by 1, first dat = 1.

Source files
------------

// File: rtl/xdevice_gen.sv
// Burst traffic generator: NPKT address/data packets per start pulse on a
// valid/ack source port, with incrementing or LFSR payload and a programmable gap.
module xdevice_gen #(
  parameter int DW = 4,
  parameter int AW = 2,
  parameter int NPKT = 4,
  parameter int INIT = 0,
  parameter int GAP = 1,
  parameter logic [DW-1:0] TAPS = DW'(4'b1100)
) (
  input  logic          clk_i2,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          acktx,
  output logic [AW-1:0] adr_i,
  output logic [DW-1:0] dat_i,
  output logic          validtx,
  output logic          busy_o,
  output logic          done_o,
  output logic [7:0]    sent_o
);

  // Handshake: a packet moves on a rising edge where validtx & acktx are both
  // high; adr_i/dat_i stay frozen while validtx is high and acktx is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DW-1:0] INC_SEED  = DW'(INIT + 1);
  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [DW-1:0] LFSR_SEED = (INC_SEED == '0) ? DW'(1) : INC_SEED;
  localparam logic [AW-1:0] ADR_SEED  = AW'(INIT);
  localparam logic [7:0]    LAST_IDX  = 8'(NPKT - 1);
  localparam logic [3:0]    GAP_LD    = 4'(GAP);

  state_t        state, state_n;
  logic [7:0]    idx;
  logic [3:0]    gap_cnt;
  logic          mode_q;
  logic          xfer;
  logic          load_first;
  logic          load_next;
  logic          gap_load;
  logic [DW-1:0] dat_inc;
  logic [DW-1:0] dat_lfsr;

  assign xfer     = (state == SEND) && acktx;
  assign dat_inc  = DW'(32'(dat_i) + 32'd4);
  assign dat_lfsr = {dat_i[DW-2:0], ^(dat_i & TAPS)};

  assign validtx = (state == SEND);
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);

  always_ff @(posedge clk_i2 or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    gap_load   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load_first = 1'b1;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else if (GAP == 0) begin
            load_next = 1'b1;
          end else begin
            gap_load = 1'b1;
            state_n  = WAIT;
          end
        end
      end
      WAIT: begin
        if (gap_cnt <= 4'd1) begin
          load_next = 1'b1;
          state_n   = SEND;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i2 or posedge rst_i) begin
    if (rst_i) begin
      idx     <= '0;
      gap_cnt <= '0;
      mode_q  <= 1'b0;
      adr_i   <= '0;
      dat_i   <= '0;
      sent_o  <= '0;
    end else begin
      if (load_first) begin
        idx    <= '0;
        sent_o <= '0;
        mode_q <= mode_i;
        adr_i  <= ADR_SEED;
        dat_i  <= mode_i ? LFSR_SEED : INC_SEED;
      end
      if (xfer) begin
        sent_o <= sent_o + 8'd1;
      end
      if (load_next) begin
        idx   <= idx + 8'd1;
        adr_i <= adr_i + AW'(1);
        dat_i <= mode_q ? dat_lfsr : dat_inc;
      end
      if (gap_load) begin
        gap_cnt <= GAP_LD;
      end else if (state == WAIT) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_xdevice_gen.sv
// Bench for xdevice_gen: four instances with different parameters share the
// control inputs; bursts are checked against a formula-based packet model.
module tb_xdevice_gen;

  typedef struct {
    int inst;
    bit mode;
    int lat;
    bit abuse;
    int vec_sel;
    int exp_sent;
  } burst_t;

  typedef struct {
    logic [3:0] dat;
    logic [1:0] adr;
  } pkt_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       mode = 1'b0;
  logic       ack  = 1'b0;
  logic       start_w [4];
  logic [1:0] adr_w   [4];
  logic [3:0] dat_w   [4];
  logic       valid_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic [7:0] sent_w  [4];

  int npkt_p [4] = '{4, 4, 15, 4};
  int gap_p  [4] = '{1, 0, 1, 1};
  int init_p [4] = '{0, 0, 0, 15};

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  always #5 clk = ~clk;

  xdevice_gen u_def (
    .clk_i2(clk), .rst_i(rst), .start_i(start_w[0]), .mode_i(mode), .acktx(ack),
    .adr_i(adr_w[0]), .dat_i(dat_w[0]), .validtx(valid_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .sent_o(sent_w[0])
  );

  xdevice_gen #(.GAP(0)) u_gap0 (
    .clk_i2(clk), .rst_i(rst), .start_i(start_w[1]), .mode_i(mode), .acktx(ack),
    .adr_i(adr_w[1]), .dat_i(dat_w[1]), .validtx(valid_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .sent_o(sent_w[1])
  );

  xdevice_gen #(.NPKT(15)) u_lfsr (
    .clk_i2(clk), .rst_i(rst), .start_i(start_w[2]), .mode_i(mode), .acktx(ack),
    .adr_i(adr_w[2]), .dat_i(dat_w[2]), .validtx(valid_w[2]), .busy_o(busy_w[2]),
    .done_o(done_w[2]), .sent_o(sent_w[2])
  );

  xdevice_gen #(.INIT(15)) u_initf (
    .clk_i2(clk), .rst_i(rst), .start_i(start_w[3]), .mode_i(mode), .acktx(ack),
    .adr_i(adr_w[3]), .dat_i(dat_w[3]), .validtx(valid_w[3]), .busy_o(busy_w[3]),
    .done_o(done_w[3]), .sent_o(sent_w[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet idx of a burst as {adr, dat}, from the arithmetic pattern rules.
  function automatic logic [5:0] exp_pkt(input int inst, input bit md, input int idx);
    int d;
    int fb;
    if (!md) begin
      d = (init_p[inst] + 1 + 4 * idx) % 16;
    end else begin
      d = (init_p[inst] + 1) % 16;
      if (d == 0) d = 1;
      for (int i = 0; i < idx; i++) begin
        fb = $countones(d & 12) % 2;
        d  = (d * 2 + fb) % 16;
      end
    end
    return {2'((init_p[inst] + idx) % 4), 4'(d)};
  endfunction

  task automatic run_burst(input int inst, input bit md, input int lat, input bit abuse);
    int   gap_left;
    int   wait_cnt;
    int   sent_exp;
    logic exp_valid;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < npkt_p[inst]; i++) exp_q.push_back(exp_pkt(inst, md, i));
    @(negedge clk);
    mode = md;
    start_w[inst] = 1'b1;
    ack = (lat == 0);
    @(negedge clk);
    start_w[inst] = 1'b0;
    mode = ~md;
    check("busy_after_start", busy_w[inst], 1);
    gap_left = 0;
    wait_cnt = 0;
    sent_exp = 0;
    for (int cyc = 0; cyc < 2000 && exp_q.size() > 0; cyc++) begin
      exp_valid = (gap_left == 0);
      check("validtx", valid_w[inst], exp_valid);
      check("sent", sent_w[inst], sent_exp);
      if (exp_valid) begin
        check("packet", {adr_w[inst], dat_w[inst]}, exp_q[0]);
        if (lat != 0) ack = (wait_cnt == lat);
        wait_cnt++;
      end else begin
        gap_left--;
        if (lat != 0) ack = 1'b0;
      end
      start_w[inst] = abuse && (cyc == 0);
      if (exp_valid && ack) begin
        obs_q.push_back({adr_w[inst], dat_w[inst]});
        void'(exp_q.pop_front());
        sent_exp++;
        wait_cnt = 0;
        gap_left = gap_p[inst];
      end
      @(negedge clk);
    end
    start_w[inst] = 1'b0;
    check("burst_timeout", exp_q.size(), 0);
    check("done_pulse", done_w[inst], 1);
    check("done_validtx", valid_w[inst], 0);
    check("done_busy", busy_w[inst], 1);
    check("done_sent", sent_w[inst], sent_exp);
    start_w[inst] = abuse;
    @(negedge clk);
    start_w[inst] = 1'b0;
    ack = 1'b0;
    check("idle_done", done_w[inst], 0);
    check("idle_busy", busy_w[inst], 0);
    check("idle_validtx", valid_w[inst], 0);
    check("idle_sent_hold", sent_w[inst], sent_exp);
  endtask

  initial begin
    burst_t     bt [5];
    pkt_t       inc_vec [4];
    pkt_t       lfsr_vec [15];
    logic [3:0] inc_lit [4]   = '{4'h1, 4'h5, 4'h9, 4'hD};
    logic [3:0] lfsr_lit [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                  4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int inst;

    for (int i = 0; i < 4; i++) start_w[i] = 1'b0;
    for (int i = 0; i < 4; i++) inc_vec[i] = '{inc_lit[i], 2'(i)};
    for (int i = 0; i < 15; i++) lfsr_vec[i] = '{lfsr_lit[i], 2'(i % 4)};
    // inst, mode, ack latency, abuse, reference vector, expected sent_o
    bt[0] = '{0, 1'b0, 0, 1'b0, 0, 4};
    bt[1] = '{0, 1'b0, 3, 1'b1, 0, 4};
    bt[2] = '{1, 1'b0, 0, 1'b0, 0, 4};
    bt[3] = '{2, 1'b1, 0, 1'b0, 1, 15};
    bt[4] = '{3, 1'b1, 1, 1'b1, 2, 4};

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_validtx", valid_w[i], 0);
      check("rst_busy", busy_w[i], 0);
      check("rst_done", done_w[i], 0);
      check("rst_adr_dat", {adr_w[i], dat_w[i]}, 0);
      check("rst_sent", sent_w[i], 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_sent", sent_w[0], 0);
    check("idle_ack_validtx", valid_w[0], 0);
    ack = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_burst(bt[t].inst, bt[t].mode, bt[t].lat, bt[t].abuse);
      check("vec_sent", sent_w[bt[t].inst], bt[t].exp_sent);
      check("vec_count", obs_q.size(), bt[t].exp_sent);
      for (int i = 0; i < obs_q.size() && i < 15; i++) begin
        if (bt[t].vec_sel == 0 && i < 4)
          check("vec_inc", obs_q[i], {inc_vec[i].adr, inc_vec[i].dat});
        else if (bt[t].vec_sel == 1)
          check("vec_lfsr", obs_q[i], {lfsr_vec[i].adr, lfsr_vec[i].dat});
        else if (bt[t].vec_sel == 2 && i < 4)
          check("vec_initf", obs_q[i], {2'((i + 3) % 4), lfsr_vec[i].dat});
      end
    end

    // Reset in the middle of a burst, between clock edges, with ack held high.
    @(negedge clk);
    mode = 1'b0;
    start_w[0] = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy_w[0], 1);
    rst = 1'b1;
    #1;
    check("mid_rst_validtx", valid_w[0], 0);
    check("mid_rst_adr_dat", {adr_w[0], dat_w[0]}, 0);
    check("mid_rst_sent", sent_w[0], 0);
    check("mid_rst_busy", busy_w[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sent", sent_w[0], 0);
    check("post_rst_validtx", valid_w[0], 0);
    ack = 1'b0;
    run_burst(0, 1'b0, 0, 1'b0);
    if (obs_q.size() > 0) check("post_rst_pkt0", obs_q[0], {2'd0, 4'd1});
    else check("post_rst_pkt0_missing", obs_q.size(), 1);

    for (int r = 0; r < 16; r++) begin
      inst = int'($urandom_range(0, 3));
      run_burst(inst, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
      check("rand_sent", sent_w[inst], npkt_p[inst]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
